// File: rtl/resource_dispatch_pkg.sv
// Shared constants and helpers for resource_dispatch and its sub-blocks.
package resource_dispatch_pkg;

  localparam int DEF_NUM_UNITS       = 2;
  localparam int DEF_CTL_BITS        = 16;
  localparam int DEF_DAT_BYTS        = 8;
  localparam int DEF_MAX_OUTSTANDING = 8;

  // Index width that stays at least one bit even for a single-entry range.
  function automatic int min1_clog2(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/resource_dispatch_if.sv
// Single-beat valid/ready stream: source drives the beat, sink drives rdy.
interface if_axi_stream import resource_dispatch_pkg::*; #(
  parameter int DAT_BYTS = DEF_DAT_BYTS,
  parameter int CTL_BITS = DEF_CTL_BITS
);
  localparam int DAT_BITS = DAT_BYTS * 8;
  localparam int MOD_BITS = min1_clog2(DAT_BYTS);

  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic [DAT_BITS-1:0] dat;
  logic [MOD_BITS-1:0] mod;
  logic [CTL_BITS-1:0] ctl;

  // source acts as the master side, sink as the slave side
  modport source (output val, sop, eop, err, dat, mod, ctl, input rdy);
  modport sink   (input val, sop, eop, err, dat, mod, ctl, output rdy);

endinterface

// File: rtl/resource_dispatch_fifo.sv
// Order FIFO holding the unit index of every dispatched request; the extra
// pointer wrap bit distinguishes full from empty.
module resource_dispatch_fifo import resource_dispatch_pkg::*; #(
  parameter int WIDTH = 1,
  parameter int DEPTH = DEF_MAX_OUTSTANDING
) (
  input  logic             clk_sys,
  input  logic             rst_b,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = min1_clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/resource_dispatch.sv
// Spreads one request stream round-robin over NUM_UNITS units and merges the
// results back in request order. RESOURCE_DISPATCH_OUT_REG_EN registers o_rsp.
module resource_dispatch import resource_dispatch_pkg::*; #(
  parameter int NUM_UNITS       = DEF_NUM_UNITS,
  parameter int CTL_BITS        = DEF_CTL_BITS,
  parameter int DAT_BYTS        = DEF_DAT_BYTS,
  parameter int DAT_BITS        = DAT_BYTS * 8,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  if_axi_stream.sink                         i_req,
  if_axi_stream.source                       o_unit [NUM_UNITS],
  if_axi_stream.sink                         i_unit [NUM_UNITS],
  if_axi_stream.source                       o_rsp,
  output logic [$clog2(MAX_OUTSTANDING):0]   o_outstanding
);
  localparam int UNIT_BITS = min1_clog2(NUM_UNITS);
  localparam int MOD_BITS  = min1_clog2(DAT_BYTS);

  typedef struct packed {
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    logic                sop;
    logic                eop;
    logic                err;
    logic [MOD_BITS-1:0] mod;
  } beat_t;

  beat_t                req_beat, head_beat, out_beat;
  beat_t                unit_beat [NUM_UNITS];
  logic [NUM_UNITS-1:0] unit_rdy, unit_val, res_val, res_rdy;
  logic [UNIT_BITS-1:0] rr, cand, head;
  logic                 cand_found, req_rdy, full, empty, push, pop;
  logic                 head_val, sink_rdy, out_val;

  assign req_beat = {i_req.dat, i_req.ctl, i_req.sop, i_req.eop, i_req.err, i_req.mod};

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
    assign unit_rdy[g]    = o_unit[g].rdy;
    assign o_unit[g].val  = unit_val[g];
    assign o_unit[g].dat  = req_beat.dat;
    assign o_unit[g].ctl  = req_beat.ctl;
    assign o_unit[g].sop  = req_beat.sop;
    assign o_unit[g].eop  = req_beat.eop;
    assign o_unit[g].err  = req_beat.err;
    assign o_unit[g].mod  = req_beat.mod;
    assign res_val[g]     = i_unit[g].val;
    assign unit_beat[g]   = {i_unit[g].dat, i_unit[g].ctl, i_unit[g].sop,
                             i_unit[g].eop, i_unit[g].err, i_unit[g].mod};
    assign i_unit[g].rdy  = res_rdy[g];
  end

  always_comb begin
    cand_found = 1'b0;
    cand       = rr;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (!cand_found && unit_rdy[UNIT_BITS'((int'(rr) + i) % NUM_UNITS)]) begin
        cand_found = 1'b1;
        cand       = UNIT_BITS'((int'(rr) + i) % NUM_UNITS);
      end
    end
  end

  assign req_rdy   = i_rst && cand_found && !full;
  assign i_req.rdy = req_rdy;
  assign push      = i_req.val && req_rdy;

  // A unit only sees valid when the order FIFO also takes the entry, so a
  // unit can never accept a request that was not recorded.
  always_comb begin
    unit_val = '0;
    if (push) unit_val[cand] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)    rr <= '0;
    else if (push) rr <= (int'(cand) + 1 == NUM_UNITS) ? '0 : cand + 1'b1;
  end

  resource_dispatch_fifo #(
    .WIDTH (UNIT_BITS),
    .DEPTH (MAX_OUTSTANDING)
  ) u_order (
    .clk_sys   (i_clk),
    .rst_b     (i_rst),
    .push      (push),
    .push_data (cand),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  assign head_val  = !empty && res_val[head];
  assign head_beat = unit_beat[head];
  assign pop       = head_val && sink_rdy;

  always_comb begin
    res_rdy = '0;
    if (!empty) res_rdy[head] = sink_rdy;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)             o_outstanding <= '0;
    else if (push && !pop)  o_outstanding <= o_outstanding + 1'b1;
    else if (pop && !push)  o_outstanding <= o_outstanding - 1'b1;
  end

`ifdef RESOURCE_DISPATCH_OUT_REG_EN
  beat_t main_q, spare_q;
  logic  main_val, spare_val;

  // The spare slot catches the beat accepted while o_rsp was stalling.
  assign sink_rdy = !spare_val;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      main_val  <= 1'b0;
      spare_val <= 1'b0;
      main_q    <= '0;
      spare_q   <= '0;
    end else if (!main_val || o_rsp.rdy) begin
      if (spare_val) begin
        main_q    <= spare_q;
        main_val  <= 1'b1;
        spare_val <= 1'b0;
      end else begin
        main_val <= pop;
        if (pop) main_q <= head_beat;
      end
    end else if (pop) begin
      spare_q   <= head_beat;
      spare_val <= 1'b1;
    end
  end

  assign out_val  = main_val;
  assign out_beat = main_q;
`else
  assign sink_rdy = o_rsp.rdy;
  assign out_val  = head_val;
  assign out_beat = head_beat;
`endif

  assign o_rsp.val = out_val;
  assign o_rsp.dat = out_beat.dat;
  assign o_rsp.ctl = out_beat.ctl;
  assign o_rsp.sop = out_beat.sop;
  assign o_rsp.eop = out_beat.eop;
  assign o_rsp.err = out_beat.err;
  assign o_rsp.mod = out_beat.mod;

endmodule

// File: tb/tb_resource_dispatch.sv
// Bench for resource_dispatch: vector table, directed corner sequences and a
// randomized run against a queue-based model of dispatch and in-order merge.
module tb_resource_dispatch;
  import resource_dispatch_pkg::*;

  localparam int N    = 2;
  localparam int CTL  = 16;
  localparam int BYTS = 8;
  localparam int DB   = BYTS * 8;
  localparam int MAXO = 8;
  localparam int MODB = 3;

  typedef struct packed {
    logic [DB-1:0]   dat;
    logic [CTL-1:0]  ctl;
    logic            sop;
    logic            eop;
    logic            err;
    logic [MODB-1:0] mod;
  } beat_t;

  typedef struct { beat_t b; int rdy_at; } uent_t;
  typedef struct { int k; beat_t b; } ord_t;
  typedef struct {
    logic           req_val;
    logic [N-1:0]   urdy;
    logic [CTL-1:0] ctl;
    logic           exp_rdy;
    logic [N-1:0]   exp_uval;
    int             exp_out;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                  req_val, rsp_rdy;
  beat_t                 req_beat, rsp_beat;
  logic [N-1:0]          ureq_val, ureq_rdy, ursp_val, ursp_rdy;
  beat_t                 ureq_beat [N];
  beat_t                 ursp_beat [N];
  logic [$clog2(MAXO):0] outstanding;

  if_axi_stream #(.DAT_BYTS(BYTS), .CTL_BITS(CTL)) req ();
  if_axi_stream #(.DAT_BYTS(BYTS), .CTL_BITS(CTL)) rsp ();
  if_axi_stream #(.DAT_BYTS(BYTS), .CTL_BITS(CTL)) unit_req [N] ();
  if_axi_stream #(.DAT_BYTS(BYTS), .CTL_BITS(CTL)) unit_rsp [N] ();

  assign req.val = req_val;
  assign {req.dat, req.ctl, req.sop, req.eop, req.err, req.mod} = req_beat;
  assign rsp.rdy = rsp_rdy;
  assign rsp_beat = {rsp.dat, rsp.ctl, rsp.sop, rsp.eop, rsp.err, rsp.mod};

  for (genvar g = 0; g < N; g++) begin : g_map
    assign ureq_val[g]     = unit_req[g].val;
    assign ureq_beat[g]    = {unit_req[g].dat, unit_req[g].ctl, unit_req[g].sop,
                              unit_req[g].eop, unit_req[g].err, unit_req[g].mod};
    assign unit_req[g].rdy = ureq_rdy[g];
    assign unit_rsp[g].val = ursp_val[g];
    assign {unit_rsp[g].dat, unit_rsp[g].ctl, unit_rsp[g].sop,
            unit_rsp[g].eop, unit_rsp[g].err, unit_rsp[g].mod} = ursp_beat[g];
    assign ursp_rdy[g]     = unit_rsp[g].rdy;
  end

  resource_dispatch #(
    .NUM_UNITS       (N),
    .CTL_BITS        (CTL),
    .DAT_BYTS        (BYTS),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_req         (req),
    .o_unit        (unit_req),
    .i_unit        (unit_rsp),
    .o_rsp         (rsp),
    .o_outstanding (outstanding)
  );

  int           n_chk = 0;
  int           n_pass = 0;
  int           cyc = 0;
  int           lat [N];
  uent_t        uq [N][$];
  ord_t         ord [$];
  logic [CTL-1:0] got [$];
  vec_t         tbl [11];
  int           rr_m, k, h;
  logic         found, exp_rdy, exp_rsp_val, saw_stall;
  logic [N-1:0] exp_uval, exp_urdy;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic beat_t rand_beat(input logic [CTL-1:0] ctl);
    beat_t b;
    b.dat = {$urandom, $urandom};
    b.ctl = ctl;
    b.sop = 1'b1;
    b.eop = 1'b1;
    b.err = 1'($urandom_range(0, 1));
    b.mod = MODB'($urandom_range(0, 7));
    return b;
  endfunction

  // Behavioural units: each returns results in its own order after lat[u] cycles.
  task automatic pre();
    for (int u = 0; u < N; u++) begin
      if (uq[u].size() > 0 && uq[u][0].rdy_at <= cyc) begin
        ursp_val[u]  = 1'b1;
        ursp_beat[u] = uq[u][0].b;
      end else begin
        ursp_val[u]  = 1'b0;
        ursp_beat[u] = '0;
      end
    end
    #1;
  endtask

  task automatic post();
    for (int u = 0; u < N; u++)
      if (ursp_val[u] && ursp_rdy[u]) void'(uq[u].pop_front());
    for (int u = 0; u < N; u++)
      if (ureq_val[u] && ureq_rdy[u]) uq[u].push_back('{b: ureq_beat[u], rdy_at: cyc + lat[u]});
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req_val  = 1'b0;
    rsp_rdy  = 1'b0;
    ureq_rdy = '0;
    ursp_val = '0;
    for (int u = 0; u < N; u++) uq[u].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_val  = 1'b0;
    rsp_rdy  = 1'b0;
    ureq_rdy = '0;
    ursp_val = '0;
    req_beat = '0;
    for (int u = 0; u < N; u++) begin
      ursp_beat[u] = '0;
      lat[u] = 1000;
    end

    #1 rst_n = 1'b0;
    @(negedge clk);
    req_val  = 1'b1;
    ureq_rdy = '1;
    req_beat = rand_beat(16'h1);
    #1;
    chk("rst_req_rdy", req.rdy, 1'b0);
    chk("rst_unit_val", ureq_val, 2'b00);
    chk("rst_rsp_val", rsp.val, 1'b0);
    chk("rst_outstanding", outstanding, 0);
    req_val = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // req_val, unit rdy, ctl, exp req.rdy, exp unit val, exp outstanding after
    tbl[0]  = '{1'b1, 2'b11, 16'd0,  1'b1, 2'b01, 1};
    tbl[1]  = '{1'b1, 2'b11, 16'd1,  1'b1, 2'b10, 2};
    tbl[2]  = '{1'b1, 2'b11, 16'd2,  1'b1, 2'b01, 3};
    tbl[3]  = '{1'b1, 2'b11, 16'd3,  1'b1, 2'b10, 4};
    tbl[4]  = '{1'b0, 2'b11, 16'd4,  1'b1, 2'b00, 4};
    tbl[5]  = '{1'b1, 2'b10, 16'd5,  1'b1, 2'b10, 5};
    tbl[6]  = '{1'b1, 2'b10, 16'd6,  1'b1, 2'b10, 6};
    tbl[7]  = '{1'b1, 2'b00, 16'd7,  1'b0, 2'b00, 6};
    tbl[8]  = '{1'b1, 2'b11, 16'd8,  1'b1, 2'b01, 7};
    tbl[9]  = '{1'b1, 2'b01, 16'd9,  1'b1, 2'b01, 8};
    tbl[10] = '{1'b1, 2'b11, 16'd10, 1'b0, 2'b00, 8};

    for (int i = 0; i < 11; i++) begin
      req_val  = tbl[i].req_val;
      req_beat = rand_beat(tbl[i].ctl);
      ureq_rdy = tbl[i].urdy;
      rsp_rdy  = 1'b0;
      pre();
      chk($sformatf("tbl%0d_req_rdy", i), req.rdy, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_unit_val", i), ureq_val, tbl[i].exp_uval);
      chk($sformatf("tbl%0d_rsp_val", i), rsp.val, 1'b0);
      for (int u = 0; u < N; u++)
        if (tbl[i].exp_uval[u]) chk($sformatf("tbl%0d_unit_beat", i), ureq_beat[u], req_beat);
      post();
      chk($sformatf("tbl%0d_outstanding", i), outstanding, tbl[i].exp_out);
    end

    // Reordering: slow unit 0 gets A, fast unit 1 gets B.
    do_reset();
    lat[0] = 10;
    lat[1] = 1;
    ureq_rdy = '1;
    rsp_rdy  = 1'b1;
    got.delete();
    saw_stall = 1'b0;
    req_val = 1'b1;
    req_beat = rand_beat(16'h00A);
    pre(); post();
    req_beat = rand_beat(16'h00B);
    pre(); post();
    req_val = 1'b0;
    for (int t = 0; t < 40 && got.size() < 2; t++) begin
      pre();
      if (ursp_val[1] && got.size() == 0 && !saw_stall) begin
        saw_stall = 1'b1;
        chk("reord_b_held_rdy", ursp_rdy[1], 1'b0);
        chk("reord_b_held_val", rsp.val, 1'b0);
      end
      if (rsp.val && rsp_rdy) got.push_back(rsp_beat.ctl);
      post();
    end
    chk("reord_stall_seen", saw_stall, 1'b1);
    chk("reord_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("reord_first", got[0], 16'h00A);
      chk("reord_second", got[1], 16'h00B);
    end

    // FIFO full: eight accepted, ninth blocked even across a pop.
    do_reset();
    lat[0] = 2;
    lat[1] = 2;
    ureq_rdy = '1;
    rsp_rdy  = 1'b0;
    req_val  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_beat = rand_beat(CTL'(i));
      pre();
      chk($sformatf("full_acc%0d", i), req.rdy, 1'b1);
      post();
    end
    chk("full_outstanding", outstanding, 8);
    req_beat = rand_beat(16'd8);
    pre();
    chk("full_block_rdy", req.rdy, 1'b0);
    chk("full_block_uval", ureq_val, 2'b00);
    post();
    rsp_rdy = 1'b1;
    pre();
    chk("full_pop_val", rsp.val, 1'b1);
    chk("full_pop_ctl", rsp_beat.ctl, 16'd0);
    chk("full_pop_block", req.rdy, 1'b0);
    post();
    rsp_rdy = 1'b0;
    chk("full_after_pop", outstanding, 7);
    pre();
    chk("full_next_rdy", req.rdy, 1'b1);
    post();
    chk("full_refill", outstanding, 8);

    // Stray result with the order FIFO empty.
    do_reset();
    req_val  = 1'b0;
    ureq_rdy = '1;
    rsp_rdy  = 1'b1;
    pre();
    ursp_val[1]  = 1'b1;
    ursp_beat[1] = rand_beat(16'h77);
    #1;
    chk("stray_rsp_val", rsp.val, 1'b0);
    chk("stray_unit_rdy", ursp_rdy, 2'b00);
    ursp_val[1] = 1'b0;
    post();

    // Reset mid-burst with three requests outstanding.
    do_reset();
    lat[0] = 1;
    lat[1] = 1;
    ureq_rdy = '1;
    rsp_rdy  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_val  = 1'b1;
      req_beat = rand_beat(CTL'(16'h30 + i));
      pre(); post();
    end
    req_val = 1'b0;
    pre();
    chk("rstmid_before_val", rsp.val, 1'b1);
    chk("rstmid_before_out", outstanding, 3);
    req_val = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_rsp_val", rsp.val, 1'b0);
    chk("rstmid_outstanding", outstanding, 0);
    chk("rstmid_req_rdy", req.rdy, 1'b0);
    chk("rstmid_unit_val", ureq_val, 2'b00);
    for (int u = 0; u < N; u++) uq[u].delete();
    ursp_val = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
    req_beat = rand_beat(16'h55);
    pre();
    chk("rstmid_first_unit0", ureq_val, 2'b01);
    post();

    // Randomized run against the ordering model.
    do_reset();
    for (int u = 0; u < N; u++) lat[u] = $urandom_range(1, 6);
    ord.delete();
    rr_m = 0;
    repeat (3000) begin
      req_val  = ($urandom_range(0, 9) < 7);
      req_beat = rand_beat(CTL'($urandom));
      for (int u = 0; u < N; u++) ureq_rdy[u] = ($urandom_range(0, 3) != 0);
      rsp_rdy = ($urandom_range(0, 1) == 1);
      pre();
      chk("rnd_outstanding", outstanding, ord.size());

      found = 1'b0;
      k = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && ureq_rdy[(rr_m + i) % N]) begin
          found = 1'b1;
          k = (rr_m + i) % N;
        end
      end
      exp_rdy  = found && (ord.size() < MAXO);
      exp_uval = '0;
      if (req_val && exp_rdy) exp_uval[k] = 1'b1;
      exp_urdy = '0;
      exp_rsp_val = 1'b0;
      if (ord.size() > 0) begin
        h = ord[0].k;
        exp_rsp_val = ursp_val[h];
        exp_urdy[h] = rsp_rdy;
      end

      chk("rnd_req_rdy", req.rdy, exp_rdy);
      chk("rnd_unit_val", ureq_val, exp_uval);
      chk("rnd_rsp_val", rsp.val, exp_rsp_val);
      chk("rnd_unit_rdy", ursp_rdy, exp_urdy);
      if (exp_rsp_val) chk("rnd_rsp_beat", rsp_beat, ord[0].b);
      if (req_val && exp_rdy) chk("rnd_unit_beat", ureq_beat[k], req_beat);
      post();

      if (exp_rsp_val && rsp_rdy) void'(ord.pop_front());
      if (req_val && exp_rdy) begin
        ord.push_back('{k: k, b: req_beat});
        rr_m = (k + 1) % N;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/resource_dispatch.md
# resource_dispatch

Sits on the resource end of a shared-resource link and spreads one tagged request stream across NUM_UNITS identical resource instances (e.g. multipliers), then merges their results back into one response stream in request order. The `ctl` field passes through untouched, so the requester-side arbiter can demux responses by the tag it inserted.

## Interface
- NUM_UNITS, 2: number of parallel resource instances (≥2).
- CTL_BITS, 16: width of `ctl`; passed through unmodified.
- DAT_BYTS, 8: data bytes per beat.
- DAT_BITS, DAT_BYTS*8: data width.
- MAX_OUTSTANDING, 8: order-FIFO depth. Must be a power of 2 and at least 2.
- i_clk  in  1  the block's single clock.
- i_rst  in  1  reset. Asynchronous, active-low: asserted at 0, released synchronously to i_clk.
- i_req  if_axi_stream.sink  DAT/CTL  incoming requests. Single-beat only (sop=eop=1).
- o_unit[NUM_UNITS]  if_axi_stream.source  DAT/CTL  request stream to each unit.
- i_unit[NUM_UNITS]  if_axi_stream.sink  DAT/CTL  result stream from each unit. Each unit must return results in its own input order.
- o_rsp  if_axi_stream.source  DAT/CTL  merged, in-order responses.
- o_outstanding  out  $clog2(MAX_OUTSTANDING)+1  requests dispatched whose response has not yet been sent.

## Operation
- **Dispatch pointer `rr`.**
  - Candidate unit = first k, searched from `rr` upward (modulo NUM_UNITS), with `o_unit[k].rdy`=1.
  - Only the candidate sees `o_unit[k].val` = `i_req.val`. All other units see val=0.
  - `o_unit[k]` copies dat/sop/eop/err/mod/ctl from `i_req`.
- **Request ready.** `i_req.rdy` = (a candidate exists) AND (order FIFO not full).
  - A full FIFO blocks the push even if a pop happens in the same cycle.
- **On a request handshake:**
  - push k into the order FIFO;
  - set `rr` ← (k+1) mod NUM_UNITS.
- **Response path.** `h` = unit index at the order-FIFO head.
  - `o_rsp` carries the `i_unit[h]` fields.
  - `o_rsp.val` = `i_unit[h].val` AND FIFO not empty.
  - `i_unit[h].rdy` = `o_rsp.rdy`. All other `i_unit[j].rdy`=0, so early results from non-head units are held in those units.
- **On a response handshake:** pop the FIFO.
- **`o_outstanding`** is a counter: +1 on push, −1 on pop, unchanged when both happen in the same cycle. It never exceeds MAX_OUTSTANDING.
- **Empty FIFO:** `o_rsp.val`=0 and all `i_unit` rdy=0. A stray result is stalled, never forwarded.
- **Push to an empty FIFO in the same cycle as a unit result:** that result is not forwarded that cycle; the head is valid from the next cycle.
- **Reset asserted mid-operation:** the FIFO empties and in-flight results are lost. Units must share the same reset.

## Timing
- **Reset values:**
  - `o_rsp.val`=0;
  - all `o_unit[k].val`=0;
  - `i_req.rdy`=0 while reset is asserted;
  - `rr`=0;
  - `o_outstanding`=0.
- **Request path:** combinational, 0 cycles `i_req` → `o_unit`. Sustains 1 request/cycle while any unit is ready and the FIFO is not full.
- **Response path:** combinational, 0 cycles without the macro; registered, 1 cycle with it.
- **Throughput:** 1 response/cycle in both configurations.
- **Ordering:** responses leave in exact request-acceptance order, independent of unit latency differences.

## Configuration
- **RESOURCE_DISPATCH_OUT_REG_EN defined:** `o_rsp` is driven from a 2-entry skid register.
  - Every `o_rsp` field is a flop output; `o_rsp.val` resets to 0.
  - The `o_rsp.rdy` path to the units is broken by the skid.
  - Pop happens when a beat enters the skid, so `o_outstanding` excludes beats held in the skid.
  - Adds 1 cycle of latency; no bubbles.
- **Undefined:** fully combinational response path as described above.

## Structure
- **Shared package:** a `unit_idx_t` typedef (width $clog2(NUM_UNITS)) is not needed. Use a local parameter `UNIT_BITS` = max(1, $clog2(NUM_UNITS)).
- **One sub-module, `resource_dispatch_fifo`:**
  - synchronous FIFO, UNIT_BITS wide, MAX_OUTSTANDING deep;
  - full/empty flags via an extra wrap bit on the pointers;
  - asynchronous active-low reset.
- **Skid register:** local to the top, inside a macro guard.

## Test plan
- **Round-robin dispatch.** NUM_UNITS=2, both units always ready, 4 back-to-back requests with ctl=0..3 → dispatched to units 0,1,0,1; `o_outstanding` reaches 4.
- **Reordering.**
  - Setup: unit 0 latency 10, unit 1 latency 1; requests with ctl A, B.
  - Expected: B is stalled in unit 1 until A emerges; `o_rsp` order is A then B.
- **Busy-unit skip.** Unit 0 rdy=0, requests ctl=5,6 → both go to unit 1; `rr` ends at 0.
- **FIFO full.**
  - Setup: MAX_OUTSTANDING=8, `o_rsp.rdy`=0, 9 requests.
  - Expected: 8 accepted; `i_req.rdy`=0 on the 9th; `o_outstanding`=8.
  - Then: raise `o_rsp.rdy` for one cycle → the 9th request is accepted only in the following cycle.
- **Stray result.** Empty FIFO, `i_unit[1].val`=1 → `o_rsp.val` stays 0 and `i_unit[1].rdy`=0.
- **Reset mid-burst.** Assert i_rst=0 with 3 requests outstanding → `o_rsp.val`=0 immediately (async); `o_outstanding`=0; after release, first request goes to unit 0.
